vscale_csr_arbiter: RTL
=======================

VSCALE_CSR_ARBITER -- requirements
Module: vscale_csr_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 8, is the number of host-pending cycles tolerated before the core is stalled (range 1..255).
REQ-002 Port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-003 Port reset  input  1  synchronous active-high reset.
REQ-004 Port core_cmd  input  3  core CSR command (IDLE=0, READ=4, WRITE=5, SET=6, CLEAR=7); bit 2 high = core request.
REQ-005 Ports core_addr  input  12 and core_wdata  input  32 carry the core CSR address and write data.
REQ-006 Ports core_rdata  output  32, core_illegal  output  1 and core_stall  output  1 return read data, the illegal flag and the stall request to the core.
REQ-007 Ports host_req_valid  input  1, host_req_ready  output  1, host_req_rw  input  1 (1=write), host_req_addr  input  12 and host_req_data  input  32 form the host request channel.
REQ-008 Ports host_resp_valid  output  1, host_resp_ready  input  1, host_resp_data  output  32 and host_resp_err  output  1 form the host response channel.
REQ-009 Ports csr_cmd  output  3, csr_addr  output  12, csr_wdata  output  32, csr_rdata  input  32 and csr_illegal  input  1 connect to the shared CSR file port.

Function
REQ-010 The FSM SHALL have three states: IDLE, PEND and RESP.
REQ-011 IDLE: host_req_ready=1; on host_req_valid, rw/addr/data SHALL be captured into hold registers, the FSM SHALL go to PEND and the wait counter SHALL be cleared.
REQ-012 host_req_ready SHALL be 0 in PEND and RESP.
REQ-013 PEND, when core_cmd[2]=0: the host is granted this cycle.
REQ-014 PEND, when core_cmd[2]=1 and not starved: the core is granted and the wait counter SHALL increment, saturating at MAX_WAIT.
REQ-015 Host grant: csr_cmd SHALL be WRITE (5) if rw else READ (4), with csr_addr/csr_wdata from the hold registers; csr_rdata and csr_illegal SHALL be registered into host_resp_data/host_resp_err, and the FSM SHALL go to RESP at the next edge.
REQ-016 Core grant (any cycle without a host grant): csr_cmd/addr/wdata SHALL equal core_cmd/addr/wdata combinationally, with core_rdata=csr_rdata and core_illegal=csr_illegal.
REQ-017 During a host grant: core_rdata=0 and core_illegal=0; core_stall=1 iff core_cmd[2]=1.
REQ-018 RESP: host_resp_valid=1 and host_resp_data/err held stable; on host_resp_ready the FSM SHALL go to IDLE.
REQ-019 A new request SHALL be accepted no earlier than the cycle after the return to IDLE, so at most one host access is outstanding.
REQ-020 Host-access latency SHALL be 1 cycle from acceptance to grant when the core is idle, and response valid SHALL follow the grant by 1 cycle.
REQ-021 core_stall SHALL be 0 in every cycle without a host grant.

Reset
REQ-022 reset SHALL force IDLE, clear the wait counter and drop any held request without issuing it to the CSR port.
REQ-023 Reset values SHALL be: host_resp_valid=0, host_resp_data=0, host_resp_err=0, core_stall=0, host_req_ready=1 (from the cycle after reset deasserts).
REQ-024 A response pending in RESP at reset SHALL be discarded.

Configuration
REQ-025 Macro CSR_ARB_STARVE_EN SHALL gate starvation protection.
REQ-026 With CSR_ARB_STARVE_EN defined: in PEND with the counter equal to MAX_WAIT, the host SHALL be granted regardless of core_cmd, and core_stall SHALL assert for that one cycle if core_cmd[2]=1.
REQ-027 With CSR_ARB_STARVE_EN undefined: the counter SHALL be absent, the host SHALL wait for a core-idle cycle indefinitely, and core_stall SHALL be constant 0.

Verification
REQ-028 Core idle; host read addr 0x300 with csr_rdata=0x06 -> csr_cmd=4 one cycle after acceptance; host_resp_valid next cycle with data 0x06 and err 0.
REQ-029 Host write addr 0x340 data 0xDEADBEEF while core idle -> exactly one cycle of csr_cmd=5, csr_wdata=0xDEADBEEF.
REQ-030 Macro defined, MAX_WAIT=8, core_cmd=4 continuously, host read pending -> core granted 8 cycles; 9th PEND cycle host granted with core_stall=1 for exactly 1 cycle.
REQ-031 Macro undefined, core busy 20 cycles -> no host grant and core_stall=0 throughout; host granted in the first core-idle cycle.
REQ-032 host_resp_ready held 0 for 5 cycles -> resp_valid/data stable and host_req_ready=0; release -> IDLE, next request accepted.
REQ-033 Reset asserted in PEND -> no host csr_cmd issued and host_resp_valid=0; FSM in IDLE after reset.

Source files
------------

// File: rtl/vscale_csr_arbiter.sv
// Arbitrates the shared CSR file port between the vscale core and a host debug channel.
// Optional starvation protection is enabled by defining CSR_ARB_STARVE_EN.
module vscale_csr_arbiter #(
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  core_cmd,
  input  logic [11:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_illegal,
  output logic        core_stall,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic        host_req_rw,
  input  logic [11:0] host_req_addr,
  input  logic [31:0] host_req_data,
  output logic        host_resp_valid,
  input  logic        host_resp_ready,
  output logic [31:0] host_resp_data,
  output logic        host_resp_err,
  output logic [2:0]  csr_cmd,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_illegal
);

  localparam logic [2:0] CMD_READ  = 3'd4;
  localparam logic [2:0] CMD_WRITE = 3'd5;

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("vscale_csr_arbiter: MAX_WAIT must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  logic        hold_rw;
  logic [11:0] hold_addr;
  logic [31:0] hold_data;
  logic        starved;
  logic        host_grant;

`ifdef CSR_ARB_STARVE_EN
  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
  logic [7:0] wait_cnt;
  assign starved = (wait_cnt == WAIT_LIMIT);
`else
  assign starved = 1'b0;
`endif

  // A held request never reaches the CSR port in a cycle where reset is asserted.
  assign host_grant = (state == ST_PEND) && !reset && (!core_cmd[2] || starved);

  assign host_req_ready  = (state == ST_IDLE);
  assign host_resp_valid = (state == ST_RESP);

  // Arbiter state, request hold registers, wait counter and registered host response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      hold_rw        <= 1'b0;
      hold_addr      <= 12'h000;
      hold_data      <= 32'h0000_0000;
      host_resp_data <= 32'h0000_0000;
      host_resp_err  <= 1'b0;
`ifdef CSR_ARB_STARVE_EN
      wait_cnt       <= 8'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (host_req_valid) begin
            hold_rw   <= host_req_rw;
            hold_addr <= host_req_addr;
            hold_data <= host_req_data;
            state     <= ST_PEND;
`ifdef CSR_ARB_STARVE_EN
            wait_cnt  <= 8'd0;
`endif
          end
        end
        ST_PEND: begin
          if (host_grant) begin
            host_resp_data <= csr_rdata;
            host_resp_err  <= csr_illegal;
            state          <= ST_RESP;
          end
`ifdef CSR_ARB_STARVE_EN
          else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        ST_RESP: begin
          if (host_resp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // CSR port steering: the host owns the port only in its grant cycle, otherwise the core passes through.
  always_comb begin
    csr_cmd      = core_cmd;
    csr_addr     = core_addr;
    csr_wdata    = core_wdata;
    core_rdata   = csr_rdata;
    core_illegal = csr_illegal;
    if (host_grant) begin
      csr_cmd      = hold_rw ? CMD_WRITE : CMD_READ;
      csr_addr     = hold_addr;
      csr_wdata    = hold_data;
      core_rdata   = 32'h0000_0000;
      core_illegal = 1'b0;
    end else begin
      csr_cmd      = core_cmd;
      csr_addr     = core_addr;
      csr_wdata    = core_wdata;
      core_rdata   = csr_rdata;
      core_illegal = csr_illegal;
    end
  end

`ifdef CSR_ARB_STARVE_EN
  assign core_stall = host_grant && core_cmd[2];
`else
  assign core_stall = 1'b0;
`endif

endmodule
